apb_rr_master: RTL

Round-robin APB master that shares the single APB slave (the 16-word random-latency memory behind the APB slave wrapper) among NUM_REQ simple requesters. Each requester presents a read/write request. The block arbitrates, then drives the APB SETUP/ACCESS phases and waits for `pready_i`. It returns a one-cycle done pulse with read data, or an error on timeout. It sits between the requester logic (CPU stub, DMA stub, test generators) and the APB slave.

---
 rtl/apb_ctrl_pkg.sv | 7 +
 rtl/apb_rr_arbiter.sv | 26 ++
 rtl/apb_rr_master.sv | 131 +++++++++++++
 3 files changed

// File: rtl/apb_ctrl_pkg.sv
// apb_ctrl_pkg: shared FSM state type and default widths for the round-robin APB master
package apb_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 32;
endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: stateless rotating-priority pick, searching from last_gnt+1 upward
//   req      in  NUM_REQ  request vector
//   last_gnt in  IDX_W    index granted most recently
//   gnt_idx  out IDX_W    winning index (0 when nothing requests)
//   gnt_vld  out 1        some requester is active
module apb_rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);
    // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req[IDX_W'((int'(last_gnt) + i) % NUM_REQ)]) begin
                gnt_idx = IDX_W'((int'(last_gnt) + i) % NUM_REQ);
                gnt_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin APB master sharing one APB slave among NUM_REQ requesters
//   clk, reset (async, active-low)
//   req_i/req_rnw_i/req_addr_i/req_wdata_i  in   per-requester request, packed k*W slices
//   req_done_o/req_err_o/req_rdata_o        out  one-cycle completion pulse, error, read data
//   psel_o/penable_o/pwrite_o/paddr_o/pwdata_o out APB master side
//   prdata_i/pready_i                       in   APB slave response
module apb_rr_master
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        req_rnw_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        req_done_o,
    output logic                      req_err_o,
    output logic [DATA_W-1:0]         req_rdata_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [ADDR_W-1:0]         paddr_o,
    output logic [DATA_W-1:0]         pwdata_o,
    input  logic [DATA_W-1:0]         prdata_i,
    input  logic                      pready_i
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_gnt_q, last_gnt_d, gnt_q, gnt_d, arb_idx;
    logic               arb_vld;
    logic               write_q, write_d, err_q, err_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req      (req_i),
        .last_gnt (last_gnt_q),
        .gnt_idx  (arb_idx),
        .gnt_vld  (arb_vld)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_gnt_q <= IDX_W'(NUM_REQ - 1);
            gnt_q      <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            write_q    <= write_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        write_d    = write_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: if (arb_vld) begin
                state_d    = SETUP;
                gnt_d      = arb_idx;
                last_gnt_d = arb_idx;
                err_d      = 1'b0;
                rdata_d    = '0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (arb_idx == IDX_W'(i)) begin
                        write_d = !req_rnw_i[i];
                        addr_d  = req_addr_i[i*ADDR_W +: ADDR_W];
                        wdata_d = req_wdata_i[i*DATA_W +: DATA_W];
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            // cnt_q counts ACCESS cycles already spent, so the TIMEOUT-th cycle sees TIMEOUT-1;
            // pready_i is tested first so a response in that last cycle still wins.
            ACCESS: begin
                if (pready_i) begin
                    state_d = DONE;
                    rdata_d = write_q ? '0 : prdata_i;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode only registered state, so no input reaches an output combinationally
    // and the async reset clears psel/penable at once.
    assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o   = (state_q == ACCESS);
    assign pwrite_o    = write_q;
    assign paddr_o     = addr_q;
    assign pwdata_o    = wdata_q;
    assign req_done_o  = (state_q == DONE) ? (NUM_REQ'(1) << gnt_q) : '0;
    assign req_err_o   = err_q;
    assign req_rdata_o = rdata_q;
endmodule
